// File: rtl/spi_host_fifo.sv
// SPI host controller behind a simple register bus.
// Frames written to TXDATA are queued in a TX FIFO and shifted out back-to-back
// on the selected slave. Each received frame is queued in an RX FIFO.
// CPOL, CPHA and LSB-first are configurable and latched at the start of each frame.
// Frame sequence: SETUP, 2*XFER_W sclk edges, HOLD, GAP. Each step lasts (DIV+1) clk cycles.
module spi_host_fifo #(
    parameter int AW     = 8,
    parameter int XFER_W = 8,
    parameter int SS_NB  = 8,
    parameter int FIFO_D = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       be_i,
    input  logic             we_i,
    input  logic             re_i,
    output logic [31:0]      rdata_o,
    output logic             error_o,
    output logic             intr_o,
    output logic [SS_NB-1:0] ss_o,
    output logic             sclk_o,
    output logic             sd_o,
    input  logic             sd_i
);
    localparam int SSW = (SS_NB > 1) ? $clog2(SS_NB) : 1;
    localparam int PW  = $clog2(FIFO_D);
    localparam int EW  = $clog2(2 * XFER_W) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * XFER_W - 1);
    localparam logic [PW:0]   FULL_LVL  = (PW+1)'(FIFO_D);

    localparam logic [2:0] R_CTRL    = 3'd0;
    localparam logic [2:0] R_STATUS  = 3'd1;
    localparam logic [2:0] R_DIV     = 3'd2;
    localparam logic [2:0] R_SSSEL   = 3'd3;
    localparam logic [2:0] R_TXDATA  = 3'd4;
    localparam logic [2:0] R_RXDATA  = 3'd5;
    localparam logic [2:0] R_INTR_EN = 3'd6;
    localparam logic [2:0] R_INTR_ST = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP
    } state_t;

    state_t state;

    // Software-visible registers. ctrl = {LSB, CPHA, CPOL, EN}
    logic [3:0]     ctrl;
    logic [15:0]    div;
    logic [SSW-1:0] sssel;
    logic [2:0]     intr_en;
    logic [2:0]     intr_state;

    // Per-frame copies, so that register writes during a frame apply to the next frame only
    logic           cpha_q;
    logic           lsb_q;
    logic [15:0]    div_q;

    logic [15:0]       cnt;
    logic [EW-1:0]     edge_cnt;
    logic [XFER_W-1:0] tx_sr;
    logic [XFER_W-1:0] rx_sr;

    // FIFO storage and bookkeeping
    logic [XFER_W-1:0] tx_mem [FIFO_D];
    logic [XFER_W-1:0] rx_mem [FIFO_D];
    logic [PW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
    logic [PW:0]       tx_lvl, rx_lvl;
    logic              tx_empty, tx_full, rx_empty, rx_full;

    logic        mapped, reg_we, reg_re;
    logic [2:0]  idx;
    logic        start, frame_done, busy;
    logic        tx_req, tx_push, tx_ovf;
    logic        rx_pop, rx_push, rx_ovf;
    logic [2:0]  w1c, hw_set;
    logic        sample_edge;
    logic [SS_NB-1:0]  ss_sel;
    logic [XFER_W-1:0] tx_head;
    logic        unused_bits;

    function automatic logic [XFER_W-1:0] shift_out(input logic [XFER_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic head_bit(input logic [XFER_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[XFER_W-1];
    endfunction

    // Address decode. Only 8 word registers exist, so any higher address bit set means unmapped.
    assign mapped  = ~|addr_i[AW-1:5];
    assign idx     = addr_i[4:2];
    assign reg_we  = we_i & mapped;
    assign reg_re  = re_i & mapped;
    assign error_o = (re_i & ~mapped) |
                     (we_i & (~mapped | (idx == R_STATUS) | (idx == R_RXDATA)));

    assign tx_empty = (tx_lvl == '0);
    assign tx_full  = (tx_lvl == FULL_LVL);
    assign rx_empty = (rx_lvl == '0);
    assign rx_full  = (rx_lvl == FULL_LVL);
    assign busy     = (state != ST_IDLE);
    assign tx_head  = tx_mem[tx_rp];

    assign start      = (state == ST_IDLE) & ctrl[0] & ~tx_empty;
    assign frame_done = (state == ST_HOLD) & (cnt == div_q);

    // A full FIFO still accepts a push in the same cycle as a pop, so the level stays unchanged
    assign tx_req  = reg_we & (idx == R_TXDATA) & be_i[0];
    assign tx_push = tx_req & (~tx_full | start);
    assign tx_ovf  = tx_req & ~tx_push;
    assign rx_pop  = reg_re & (idx == R_RXDATA) & ~rx_empty;
    assign rx_push = frame_done & (~rx_full | rx_pop);
    assign rx_ovf  = frame_done & ~rx_push;

    assign w1c    = (reg_we & be_i[0] & (idx == R_INTR_ST)) ? wdata_i[2:0] : 3'b000;
    assign hw_set = {rx_ovf, tx_ovf, frame_done};

    // Edges are numbered from 1. Odd edges are leading edges.
    assign sample_edge = cpha_q ? edge_cnt[0] : ~edge_cnt[0];

    assign unused_bits = ^{addr_i[1:0], wdata_i, be_i[3:2]};

    // Active-low one-hot select for the currently programmed slave
    always_comb begin
        ss_sel = '1;
        for (int i = 0; i < SS_NB; i++) ss_sel[i] = (SSW'(i) != sssel);
    end

    // Register read mux. Reads of write-only and unmapped registers return 0.
    always_comb begin
        rdata_o = '0;
        if (mapped) begin
            case (idx)
                R_CTRL:    rdata_o[3:0] = ctrl;
                R_STATUS:  rdata_o = {8'h00, 8'(rx_lvl), 8'(tx_lvl), 3'b000,
                                      rx_empty, rx_full, tx_empty, tx_full, busy};
                R_DIV:     rdata_o[15:0] = div;
                R_SSSEL:   rdata_o[SSW-1:0] = sssel;
                R_RXDATA:  if (!rx_empty) rdata_o[XFER_W-1:0] = rx_mem[rx_rp];
                R_INTR_EN: rdata_o[2:0] = intr_en;
                R_INTR_ST: rdata_o[2:0] = intr_state;
                default:   rdata_o = '0;
            endcase
        end
    end

    // Control registers and interrupts. A hardware set wins over a same-cycle W1C.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl       <= '0;
            div        <= '0;
            sssel      <= '0;
            intr_en    <= '0;
            intr_state <= '0;
            intr_o     <= 1'b0;
        end else begin
            if (reg_we && be_i[0]) begin
                case (idx)
                    R_CTRL:    ctrl <= wdata_i[3:0];
                    R_DIV:     div[7:0] <= wdata_i[7:0];
                    R_SSSEL:   sssel <= wdata_i[SSW-1:0];
                    R_INTR_EN: intr_en <= wdata_i[2:0];
                    default:   ;
                endcase
            end
            if (reg_we && be_i[1] && idx == R_DIV) div[15:8] <= wdata_i[15:8];
            intr_state <= (intr_state & ~w1c) | hw_set;
            intr_o     <= |(intr_state & intr_en);
        end
    end

    // TX FIFO pointers. Reset discards the contents by clearing the pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_lvl <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (start)   tx_rp <= tx_rp + 1'b1;
            if (tx_push && !start)      tx_lvl <= tx_lvl + 1'b1;
            else if (!tx_push && start) tx_lvl <= tx_lvl - 1'b1;
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp] <= wdata_i[XFER_W-1:0];
    end

    // RX FIFO pointers. The FSM pushes into this FIFO and register reads pop from it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_lvl <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (rx_push && !rx_pop)      rx_lvl <= rx_lvl + 1'b1;
            else if (!rx_push && rx_pop) rx_lvl <= rx_lvl - 1'b1;
        end
    end

    // RX FIFO storage. The shift register holds the complete frame once the FSM is in HOLD.
    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wp] <= rx_sr;
    end

    // Frame sequencer. Drives registered ss_o, sclk_o and sd_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            ss_o     <= '1;
            sclk_o   <= 1'b0;
            sd_o     <= 1'b0;
            cnt      <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            div_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sclk_o <= ctrl[1];
                    if (start) begin
                        cpha_q   <= ctrl[2];
                        lsb_q    <= ctrl[3];
                        div_q    <= div;
                        ss_o     <= ss_sel;
                        cnt      <= '0;
                        edge_cnt <= '0;
                        rx_sr    <= '0;
                        if (ctrl[2]) begin
                            // CPHA=1: the first bit is driven on the first leading edge
                            tx_sr <= tx_head;
                            sd_o  <= 1'b0;
                        end else begin
                            // CPHA=0: the first bit must be valid before the first edge
                            tx_sr <= shift_out(tx_head, ctrl[3]);
                            sd_o  <= head_bit(tx_head, ctrl[3]);
                        end
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == div_q) begin
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else cnt <= cnt + 1'b1;
                end
                ST_SHIFT: begin
                    if (cnt == div_q) begin
                        cnt      <= '0;
                        sclk_o   <= ~sclk_o;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (sample_edge) begin
                            rx_sr <= lsb_q ? {sd_i, rx_sr[XFER_W-1:1]} : {rx_sr[XFER_W-2:0], sd_i};
                        end else begin
                            sd_o  <= head_bit(tx_sr, lsb_q);
                            tx_sr <= shift_out(tx_sr, lsb_q);
                        end
                        if (edge_cnt == LAST_EDGE) state <= ST_HOLD;
                    end else cnt <= cnt + 1'b1;
                end
                ST_HOLD: begin
                    if (cnt == div_q) begin
                        cnt   <= '0;
                        ss_o  <= '1;
                        state <= ST_GAP;
                    end else cnt <= cnt + 1'b1;
                end
                ST_GAP: begin
                    if (cnt == div_q) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_host_fifo.sv
// Directed bench for spi_host_fifo: register access, loopback timing, SPI modes, FIFO overflow,
// interrupt set/clear priority and asynchronous reset mid-frame.
module tb_spi_host_fifo;
    logic        clk, rst_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        we_i, re_i;
    logic [31:0] rdata_o;
    logic        error_o, intr_o;
    logic [7:0]  ss_o;
    logic        sclk_o, sd_o, sd_i;

    int checks = 0;
    int errors = 0;

    // Stimulus controls for the loopback path and the slave model
    logic t_loop, t_cpha, t_lsb, sd_slv;
    logic [7:0] s_tx = 8'h1B;
    logic [7:0] s_rx;
    int s_edges, s_ri, s_ti;

    // Monitor state for sclk and slave-select timing
    int cyc = 0;
    int rise_cnt, last_rise, period, ss_low;
    logic sclk_prev;

    logic [31:0] rd;
    logic er;

    spi_host_fifo #(.AW(8), .XFER_W(8), .SS_NB(8), .FIFO_D(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
        .we_i(we_i), .re_i(re_i), .rdata_o(rdata_o), .error_o(error_o), .intr_o(intr_o),
        .ss_o(ss_o), .sclk_o(sclk_o), .sd_o(sd_o), .sd_i(sd_i)
    );

    assign sd_i = t_loop ? sd_o : sd_slv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Count sclk rising edges and slave-select low cycles on slave 0
    always @(negedge clk) begin
        if (!ss_o[0]) begin
            ss_low++;
            if (sclk_o && !sclk_prev) begin
                if (rise_cnt > 0) period = cyc - last_rise;
                last_rise = cyc;
                rise_cnt++;
            end
        end
        sclk_prev = sclk_o;
    end

    // Slave model: at the start of a frame, load the first MISO bit when CPHA=0
    always @(negedge ss_o[0]) begin
        s_edges = 0; s_ri = 0; s_ti = 0; s_rx = 8'h00;
        if (!t_cpha) begin
            sd_slv = s_tx[t_lsb ? 0 : 7];
            s_ti = 1;
        end
    end

    // Slave model: sample MOSI on the sampling edge, drive MISO on the other edge
    always @(sclk_o) begin
        if (!ss_o[0] && !rst_i) begin
            s_edges++;
            if (((s_edges % 2) == 1) != t_cpha) begin
                if (s_ri < 8) s_rx[t_lsb ? s_ri : 7 - s_ri] = sd_o;
                s_ri++;
            end else begin
                if (s_ti < 8) sd_slv = s_tx[t_lsb ? s_ti : 7 - s_ti];
                s_ti++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Every access task is called just after a negedge and returns just after the next negedge
    task automatic reg_wrb(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                           output logic e);
        addr_i = a; wdata_i = d; be_i = be; we_i = 1'b1;
        #1 e = error_o;
        @(negedge clk);
        we_i = 1'b0; be_i = 4'h0;
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
        logic e;
        reg_wrb(a, d, 4'hF, e);
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [31:0] d, output logic e);
        addr_i = a; re_i = 1'b1;
        #1 d = rdata_o; e = error_o;
        @(negedge clk);
        re_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] s;
        logic e, ok;
        int n;
        ok = 1'b0; n = 0;
        @(negedge clk);
        while (!ok && n < budget) begin
            reg_rd(8'h04, s, e);
            ok = !s[0] && s[2];
            n++;
        end
        check("idle_wait", {31'b0, ok}, 32'd1);
    endtask

    initial begin
        rst_i = 1'b1; addr_i = '0; wdata_i = '0; be_i = '0; we_i = 0; re_i = 0;
        t_loop = 1'b1; t_cpha = 0; t_lsb = 0; sd_slv = 0;
        rise_cnt = 0; last_rise = 0; period = 0; ss_low = 0; sclk_prev = 0;
        repeat (2) @(negedge clk);
        check("rst_ss", {24'b0, ss_o}, 32'hFF);
        check("rst_sclk_sd_intr", {29'b0, sclk_o, sd_o, intr_o}, 32'h0);
        rst_i = 1'b0;
        @(negedge clk);
        reg_rd(8'h04, rd, er); check("rst_status", rd, 32'h14);
        reg_rd(8'h00, rd, er); check("rst_ctrl", rd, 32'h0);

        // Register access, byte enables and error responses
        reg_wr(8'h08, 32'h1234);
        reg_rd(8'h08, rd, er); check("div_rw", rd, 32'h1234);
        reg_wrb(8'h08, 32'hFFFF, 4'b0010, er);
        reg_rd(8'h08, rd, er); check("div_be", rd, 32'hFF34);
        reg_rd(8'h20, rd, er); check("unmapped_rd", {er, rd[30:0]}, 32'h8000_0000);
        reg_wrb(8'h04, 32'h1, 4'hF, er); check("ro_wr_err", {31'b0, er}, 32'd1);
        reg_rd(8'h10, rd, er); check("txdata_rd", {er, rd[30:0]}, 32'h0);
        reg_wrb(8'h10, 32'h77, 4'h0, er);
        reg_rd(8'h04, rd, er); check("tx_no_be_push", rd, 32'h14);
        reg_wr(8'h08, 32'h1);

        // Mode 0 loopback: 8 sclk pulses every 4 clocks, ss_o low for 36 cycles
        reg_wr(8'h10, 32'hA5);
        rise_cnt = 0; ss_low = 0; period = 0;
        reg_wr(8'h00, 32'h1);
        wait_idle(200);
        check("m0_pulses", rise_cnt, 8);
        check("m0_period", period, 4);
        check("m0_ss_low", ss_low, 36);
        reg_rd(8'h14, rd, er); check("m0_rxdata", rd, 32'hA5);
        reg_rd(8'h1C, rd, er); check("m0_done", rd, 32'h1);
        reg_wr(8'h1C, 32'h7);

        // All CPOL/CPHA modes against the slave model
        t_loop = 1'b0;
        for (int m = 0; m < 4; m++) begin
            logic [3:0] c;
            t_cpha = m[0];
            t_lsb = m[0] ^ m[1];
            c = {t_lsb, t_cpha, m[1], 1'b0};
            reg_wr(8'h00, {28'b0, c});
            @(negedge clk);
            check($sformatf("mode%0d_idle_sclk", m), {31'b0, sclk_o}, {31'b0, m[1]});
            reg_wr(8'h10, 32'h3C);
            reg_wr(8'h00, {28'b0, c | 4'h1});
            wait_idle(200);
            check($sformatf("mode%0d_slave_rx", m), {24'b0, s_rx}, 32'h3C);
            check($sformatf("mode%0d_edges", m), s_edges, 16);
            check($sformatf("mode%0d_end_sclk", m), {31'b0, sclk_o}, {31'b0, m[1]});
            reg_rd(8'h14, rd, er); check($sformatf("mode%0d_rxdata", m), rd, 32'h1B);
        end

        // TX overflow with EN=0, then 8 frames fill RX, then a ninth frame overflows RX
        t_loop = 1'b1;
        reg_wr(8'h00, 32'h0);
        reg_wr(8'h1C, 32'h7);
        reg_wr(8'h18, 32'h2);
        reg_wr(8'h0C, 32'h3);
        for (int i = 0; i < 9; i++) reg_wr(8'h10, 32'h10 + i);
        reg_rd(8'h04, rd, er); check("txfull_status", rd, 32'h0000_0812);
        reg_rd(8'h1C, rd, er); check("txovf_state", rd, 32'h2);
        check("txovf_intr", {31'b0, intr_o}, 32'd1);
        reg_wr(8'h00, 32'h1);
        repeat (2) @(negedge clk);
        check("sssel3_ss", {24'b0, ss_o}, 32'hF7);
        wait_idle(2000);
        reg_rd(8'h04, rd, er); check("rxfull_status", rd, 32'h0008_000C);
        reg_wr(8'h10, 32'h99);
        wait_idle(200);
        reg_rd(8'h1C, rd, er); check("rxovf_state", rd, 32'h7);
        for (int i = 0; i < 8; i++) begin
            reg_rd(8'h14, rd, er);
            check($sformatf("rx_order%0d", i), rd, 32'h10 + i);
        end
        reg_rd(8'h14, rd, er); check("rx_empty_rd", {er, rd[30:0]}, 32'h0);

        // DONE set by hardware in the same cycle as a W1C of DONE; the set must win
        reg_wr(8'h1C, 32'h7);
        reg_wr(8'h10, 32'h5A);
        repeat (36) @(negedge clk);
        reg_wr(8'h1C, 32'h1);
        reg_rd(8'h1C, rd, er); check("done_set_wins", rd, 32'h1);
        wait_idle(200);
        reg_wr(8'h1C, 32'h1);
        reg_rd(8'h1C, rd, er); check("done_w1c", rd, 32'h0);

        // Asynchronous reset during SHIFT. One RX frame is queued beforehand and must be discarded.
        reg_wr(8'h10, 32'hFF);
        repeat (15) @(negedge clk);
        check("pre_rst_ss", {24'b0, ss_o}, 32'hF7);
        rst_i = 1'b1;
        #1;
        check("midrst_ss", {24'b0, ss_o}, 32'hFF);
        check("midrst_sclk", {31'b0, sclk_o}, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        reg_rd(8'h04, rd, er); check("midrst_status", rd, 32'h14);
        reg_rd(8'h0C, rd, er); check("midrst_sssel", rd, 32'h0);
        repeat (40) @(negedge clk);
        reg_rd(8'h04, rd, er); check("midrst_no_push", rd, 32'h14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
